video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
- Raster timing source for the NTSC square-pixel video path.
- Divides the master clock into the pixel enable, runs horizontal and vertical pixel counters, and decodes active, sync and burst windows.
- Directly upstream of the LED hit judge (feeds its CK_EE_i, HCTRs_i and VCTRs_i) and of the composite encoder (feeds sync, burst and blank gating).
- Also provides a frame pulse and a frame counter for LED blink/animation logic.

Parameters:
- C_CK_DIV, 2, master clocks per pixel; CK_EE_o period; range 1..15.
- C_H_TOT, 455, pixels per line (910 clocks at 4fsc / 2).
- C_H_ACT, 320, active pixels per line, H = 0..C_H_ACT-1.
- C_H_SYNC_S, 370, first H of the horizontal sync tip.
- C_H_SYNC_W, 34, horizontal sync width in pixels.
- C_BURST_S, 408, first H of the colour burst gate.
- C_BURST_W, 18, burst gate width in pixels.
- C_V_TOT, 262, lines per frame.
- C_V_ACT, 240, active lines, V = 0..C_V_ACT-1.
- C_V_SYNC_S, 243, first vertical sync line.
- C_V_SYNC_W, 3, vertical sync lines.

Ports:
- CK_i  in  1  master clock (4fsc class).
- XARST_i  in  1  asynchronous active-low reset.
- RUN_i  in  1  synchronous run enable; low = hold raster at origin.
- CK_EE_o  out  1  pixel clock enable, one CK wide.
- HCTRs_o  out  9  horizontal pixel counter, 0..C_H_TOT-1.
- VCTRs_o  out  9  line counter, 0..C_V_TOT-1. Downstream 8-bit consumers use [7:0] and must gate with ACTIVE_o.
- ACTIVE_o  out  1  visible pixel.
- HSYNC_o  out  1  horizontal sync window, active high.
- VSYNC_o  out  1  vertical sync line, active high.
- CSYNC_o  out  1  composite sync: VSYNC_o ? ~HSYNC_o : HSYNC_o.
- BURST_o  out  1  burst gate.
- FRAME_o  out  1  frame start strobe.
- FRAME_CTRs_o  out  8  completed-frame count, wraps.

Behaviour:
- Reset (XARST_i low, asynchronous): divider = 0. All outputs = 0, including counters and FRAME_CTRs_o.
- Divider: counts 0..C_CK_DIV-1 while RUN_i = 1.
  - CK_EE_o = 1 in exactly the CK cycle where the divider = C_CK_DIV-1.
  - After reset release with RUN_i = 1, the first CK_EE_o is high on the C_CK_DIV-th rising edge.
  - C_CK_DIV = 1: CK_EE_o is constantly 1 while running.
- Counter advance: counters change only on the CK edge that ends a CK_EE_o = 1 cycle. Each counter value is therefore stable for C_CK_DIV clocks.
- H counter: H == C_H_TOT-1 -> H = 0 and V advances. Otherwise H + 1.
- V counter: V == C_V_TOT-1 at line end -> V = 0. No other wrap exists.
- Decoded flags are registered and aligned to the counters: in any cycle each flag reflects the HCTRs_o/VCTRs_o values presented in that same cycle. There is zero skew between counters and flags.
  - ACTIVE_o = H < C_H_ACT and V < C_V_ACT.
  - HSYNC_o = C_H_SYNC_S <= H < C_H_SYNC_S + C_H_SYNC_W.
  - VSYNC_o = C_V_SYNC_S <= V < C_V_SYNC_S + C_V_SYNC_W.
  - BURST_o = C_BURST_S <= H < C_BURST_S + C_BURST_W, and forced 0 on any line where VSYNC_o = 1.
  - CSYNC_o follows HSYNC_o/VSYNC_o per the formula above, with the same alignment.
- FRAME_o = 1 only in the CK cycle where CK_EE_o = 1 and H = 0 and V = 0. This gives one CK pulse per frame.
- FRAME_CTRs_o: increments by 1 on the edge where H = C_H_TOT-1, V = C_V_TOT-1 and CK_EE_o = 1. Wraps 255 -> 0.
- RUN_i = 0: takes effect on the next edge.
  - Divider is cleared and CK_EE_o = 0.
  - H = V = 0, with flags decoded at (0,0).
  - FRAME_CTRs_o holds its value.
  - FRAME_o = 0 because CK_EE_o = 0.
- RUN_i 0 -> 1: behaves as after reset. The first CK_EE_o arrives after C_CK_DIV edges and produces a FRAME_o at (0,0).
- Reset mid-frame: all state clears immediately; there is no partial-line completion.
- Parameter legality is the integrator's responsibility. Windows must fit inside the H/V totals, and the sync and burst windows must not overlap.

Test Plan:
- Reset and start: hold XARST_i low, then release with RUN_i = 1.
  - All outputs are 0 during reset.
  - CK_EE_o is high on edges 2, 4, 6, … (C_CK_DIV = 2).
  - FRAME_o = 1 together with the first CK_EE_o; HCTRs_o reads 1 after the following edge.
- Line wrap: run to H = 454, V = 5.
  - Next advance gives H = 0, V = 6.
  - HSYNC_o is high for H = 370..403 and low at 369 and 404.
  - BURST_o is high for H = 408..425.
  - ACTIVE_o is high for H = 0..319 and low at 320.
- Frame wrap: from H = 454, V = 261 with FRAME_CTRs_o = 255.
  - Next advance gives (0,0), FRAME_o pulses for exactly one CK, and FRAME_CTRs_o = 0.
  - Repeat over two frames: FRAME_CTRs_o = 1 after the first, 2 after the second.
- Vertical sync lines: on V = 243..245, VSYNC_o = 1, BURST_o = 0 for all H, and CSYNC_o = ~HSYNC_o. On V = 242 and V = 246, VSYNC_o = 0.
- Run gating: drop RUN_i at H = 100, V = 50.
  - Next CK gives CK_EE_o = 0, H = V = 0, ACTIVE_o = 1.
  - FRAME_CTRs_o is unchanged and FRAME_o stays low while RUN_i = 0.
  - Raise RUN_i: CK_EE_o follows after 2 edges, together with FRAME_o.
- Reset mid-frame and divide 1: assert XARST_i asynchronously at H = 200, V = 100.
  - Outputs clear without waiting for a clock edge.
  - Repeat with C_CK_DIV = 1: CK_EE_o is constantly high and the counter advances every CK.

Source files
------------

// File: rtl/video_timing_gen_if.sv
`timescale 1ns/1ps
// Raster timing bundle: run enable in, pixel enable, counters and decoded windows out.
// master = timing generator, slave = consumer that owns RUN_i.
interface video_timing_gen_if;
  logic       RUN_i;
  logic       CK_EE_o;
  logic [8:0] HCTRs_o;
  logic [8:0] VCTRs_o;
  logic       ACTIVE_o;
  logic       HSYNC_o;
  logic       VSYNC_o;
  logic       CSYNC_o;
  logic       BURST_o;
  logic       FRAME_o;
  logic [7:0] FRAME_CTRs_o;

  modport master (
    input  RUN_i,
    output CK_EE_o, HCTRs_o, VCTRs_o, ACTIVE_o, HSYNC_o, VSYNC_o,
           CSYNC_o, BURST_o, FRAME_o, FRAME_CTRs_o
  );

  modport slave (
    output RUN_i,
    input  CK_EE_o, HCTRs_o, VCTRs_o, ACTIVE_o, HSYNC_o, VSYNC_o,
           CSYNC_o, BURST_o, FRAME_o, FRAME_CTRs_o
  );
endinterface

// File: rtl/video_timing_gen.sv
`timescale 1ns/1ps
// NTSC raster timing source: pixel enable, H/V counters, registered window flags, frame strobe/count.
// Latency: flags share the register stage of the counters (zero skew); backpressure: none, free-running while RUN_i.
module video_timing_gen #(
  parameter int unsigned C_CK_DIV   = 2,
  parameter int unsigned C_H_TOT    = 455,
  parameter int unsigned C_H_ACT    = 320,
  parameter int unsigned C_H_SYNC_S = 370,
  parameter int unsigned C_H_SYNC_W = 34,
  parameter int unsigned C_BURST_S  = 408,
  parameter int unsigned C_BURST_W  = 18,
  parameter int unsigned C_V_TOT    = 262,
  parameter int unsigned C_V_ACT    = 240,
  parameter int unsigned C_V_SYNC_S = 243,
  parameter int unsigned C_V_SYNC_W = 3
) (
  input  logic                CK_i,
  input  logic                XARST_i,
  video_timing_gen_if.master  vt
);

  localparam logic [3:0] DIV_LAST = 4'(C_CK_DIV - 1);
  localparam logic [8:0] H_LAST   = 9'(C_H_TOT - 1);
  localparam logic [8:0] V_LAST   = 9'(C_V_TOT - 1);
  localparam logic [9:0] H_ACT    = 10'(C_H_ACT);
  localparam logic [9:0] HS_LO    = 10'(C_H_SYNC_S);
  localparam logic [9:0] HS_HI    = 10'(C_H_SYNC_S + C_H_SYNC_W);
  localparam logic [9:0] BU_LO    = 10'(C_BURST_S);
  localparam logic [9:0] BU_HI    = 10'(C_BURST_S + C_BURST_W);
  localparam logic [9:0] V_ACT    = 10'(C_V_ACT);
  localparam logic [9:0] VS_LO    = 10'(C_V_SYNC_S);
  localparam logic [9:0] VS_HI    = 10'(C_V_SYNC_S + C_V_SYNC_W);

  logic [3:0] div_q, div_d;
  logic       ee_q, ee_d;
  logic [8:0] h_q, h_d, v_q, v_d;
  logic [7:0] fctr_q, fctr_d;
  logic       act_q, act_d, hs_q, hs_d, vs_q, vs_d;
  logic       cs_q, cs_d, bu_q, bu_d, frm_q, frm_d;
  logic [9:0] h_ext, v_ext;

  // The enable is registered, so it goes high C_CK_DIV edges after start and the
  // counters step on the edge that closes that enabled cycle.
  always_comb begin
    div_d  = '0;
    ee_d   = 1'b0;
    h_d    = '0;
    v_d    = '0;
    fctr_d = fctr_q;
    if (vt.RUN_i) begin
      ee_d  = (div_q == DIV_LAST);
      div_d = ee_d ? 4'd0 : div_q + 4'd1;
      h_d   = h_q;
      v_d   = v_q;
      if (ee_q) begin
        if (h_q == H_LAST) begin
          h_d = '0;
          if (v_q == V_LAST) begin
            v_d    = '0;
            fctr_d = fctr_q + 8'd1;
          end else begin
            v_d = v_q + 9'd1;
          end
        end else begin
          h_d = h_q + 9'd1;
        end
      end
    end
  end

  // Flags decode the next counter values so they land in the same register stage.
  always_comb begin
    h_ext = {1'b0, h_d};
    v_ext = {1'b0, v_d};
    act_d = (h_ext < H_ACT) && (v_ext < V_ACT);
    hs_d  = (h_ext >= HS_LO) && (h_ext < HS_HI);
    vs_d  = (v_ext >= VS_LO) && (v_ext < VS_HI);
    cs_d  = vs_d ? ~hs_d : hs_d;
    bu_d  = (h_ext >= BU_LO) && (h_ext < BU_HI) && !vs_d;
    frm_d = ee_d && (h_d == 9'd0) && (v_d == 9'd0);
  end

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      div_q  <= '0;
      ee_q   <= 1'b0;
      h_q    <= '0;
      v_q    <= '0;
      fctr_q <= '0;
      act_q  <= 1'b0;
      hs_q   <= 1'b0;
      vs_q   <= 1'b0;
      cs_q   <= 1'b0;
      bu_q   <= 1'b0;
      frm_q  <= 1'b0;
    end else begin
      div_q  <= div_d;
      ee_q   <= ee_d;
      h_q    <= h_d;
      v_q    <= v_d;
      fctr_q <= fctr_d;
      act_q  <= act_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      cs_q   <= cs_d;
      bu_q   <= bu_d;
      frm_q  <= frm_d;
    end
  end

  assign vt.CK_EE_o      = ee_q;
  assign vt.HCTRs_o      = h_q;
  assign vt.VCTRs_o      = v_q;
  assign vt.ACTIVE_o     = act_q;
  assign vt.HSYNC_o      = hs_q;
  assign vt.VSYNC_o      = vs_q;
  assign vt.CSYNC_o      = cs_q;
  assign vt.BURST_o      = bu_q;
  assign vt.FRAME_o      = frm_q;
  assign vt.FRAME_CTRs_o = fctr_q;

endmodule

// File: tb/tb_video_timing_gen.sv
`timescale 1ns/1ps
// Directed bench: dut_a uses the NTSC defaults at divide 2; dut_b uses a shrunken raster at
// divide 1 so frame counting and vertical sync lines fit in a short run.
module tb_video_timing_gen;
  logic clk = 1'b0;
  logic rst_a_n;
  logic rst_b_n;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  video_timing_gen_if ifa ();
  video_timing_gen_if ifb ();

  video_timing_gen #(.C_CK_DIV(2)) dut_a (
    .CK_i    (clk),
    .XARST_i (rst_a_n),
    .vt      (ifa)
  );

  // Small raster: 16 x 8, active 8 x 4, hsync 9..10, burst 12..13, vsync lines 5..6.
  video_timing_gen #(
    .C_CK_DIV(1), .C_H_TOT(16), .C_H_ACT(8), .C_H_SYNC_S(9), .C_H_SYNC_W(2),
    .C_BURST_S(12), .C_BURST_W(2), .C_V_TOT(8), .C_V_ACT(4), .C_V_SYNC_S(5), .C_V_SYNC_W(2)
  ) dut_b (
    .CK_i    (clk),
    .XARST_i (rst_b_n),
    .vt      (ifb)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_a_n   = 1'b0;
    rst_b_n   = 1'b0;
    ifa.RUN_i = 1'b1;
    ifb.RUN_i = 1'b1;
    step(3);
    chk("a_rst_h", int'(ifa.HCTRs_o), 0);
    chk("a_rst_v", int'(ifa.VCTRs_o), 0);
    chk("a_rst_misc", int'({ifa.CK_EE_o, ifa.ACTIVE_o, ifa.HSYNC_o, ifa.VSYNC_o, ifa.CSYNC_o,
                            ifa.BURST_o, ifa.FRAME_o, ifa.FRAME_CTRs_o}), 0);
    chk("b_rst_h", int'(ifb.HCTRs_o), 0);
    chk("b_rst_misc", int'({ifb.CK_EE_o, ifb.ACTIVE_o, ifb.HSYNC_o, ifb.VSYNC_o, ifb.CSYNC_o,
                            ifb.BURST_o, ifb.FRAME_o, ifb.FRAME_CTRs_o}), 0);

    // ---- dut_a: start-up at divide 2
    rst_a_n = 1'b1;
    step(1);
    chk("a_e1_ee", int'(ifa.CK_EE_o), 0);
    chk("a_e1_h", int'(ifa.HCTRs_o), 0);
    step(1);
    chk("a_e2_ee", int'(ifa.CK_EE_o), 1);
    chk("a_e2_frame", int'(ifa.FRAME_o), 1);
    chk("a_e2_h", int'(ifa.HCTRs_o), 0);
    chk("a_e2_active", int'(ifa.ACTIVE_o), 1);
    step(1);
    chk("a_e3_h", int'(ifa.HCTRs_o), 1);
    chk("a_e3_ee", int'(ifa.CK_EE_o), 0);
    chk("a_e3_frame", int'(ifa.FRAME_o), 0);
    step(1);
    chk("a_e4_ee", int'(ifa.CK_EE_o), 1);
    chk("a_e4_h", int'(ifa.HCTRs_o), 1);
    chk("a_e4_frame", int'(ifa.FRAME_o), 0);

    // ---- dut_a: line wrap at H=454, V=5 (edge 5459)
    step(5455);
    chk("a_prewrap_h", int'(ifa.HCTRs_o), 454);
    chk("a_prewrap_v", int'(ifa.VCTRs_o), 5);
    chk("a_prewrap_ee", int'(ifa.CK_EE_o), 0);
    chk("a_prewrap_active", int'(ifa.ACTIVE_o), 0);
    chk("a_prewrap_hsync", int'(ifa.HSYNC_o), 0);
    step(1);
    chk("a_prewrap_ee_hi", int'(ifa.CK_EE_o), 1);
    chk("a_prewrap_hold", int'(ifa.HCTRs_o), 454);
    step(1);
    chk("a_wrap_h", int'(ifa.HCTRs_o), 0);
    chk("a_wrap_v", int'(ifa.VCTRs_o), 6);

    // ---- dut_a: horizontal windows across line 6
    for (int x = 0; x < 455; x++) begin
      chk("a_line_h", int'(ifa.HCTRs_o), x);
      chk("a_line_v", int'(ifa.VCTRs_o), 6);
      chk("a_line_ee_lo", int'(ifa.CK_EE_o), 0);
      chk("a_line_hsync", int'(ifa.HSYNC_o), int'(x >= 370 && x <= 403));
      chk("a_line_csync", int'(ifa.CSYNC_o), int'(x >= 370 && x <= 403));
      chk("a_line_burst", int'(ifa.BURST_o), int'(x >= 408 && x <= 425));
      chk("a_line_active", int'(ifa.ACTIVE_o), int'(x <= 319));
      chk("a_line_vsync", int'(ifa.VSYNC_o), 0);
      step(1);
      chk("a_line_ee_hi", int'(ifa.CK_EE_o), 1);
      chk("a_line_hold", int'(ifa.HCTRs_o), x);
      step(1);
    end
    chk("a_next_line_v", int'(ifa.VCTRs_o), 7);

    // ---- dut_a: run gating at H=100, V=7
    step(200);
    chk("a_gate_h", int'(ifa.HCTRs_o), 100);
    ifa.RUN_i = 1'b0;
    step(1);
    chk("a_gate_ee", int'(ifa.CK_EE_o), 0);
    chk("a_gate_h0", int'(ifa.HCTRs_o), 0);
    chk("a_gate_v0", int'(ifa.VCTRs_o), 0);
    chk("a_gate_active", int'(ifa.ACTIVE_o), 1);
    chk("a_gate_fctr", int'(ifa.FRAME_CTRs_o), 0);
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("a_gate_frame", int'(ifa.FRAME_o), 0);
      chk("a_gate_ee_lo", int'(ifa.CK_EE_o), 0);
    end
    ifa.RUN_i = 1'b1;
    step(1);
    chk("a_rerun_e1_ee", int'(ifa.CK_EE_o), 0);
    chk("a_rerun_e1_frame", int'(ifa.FRAME_o), 0);
    step(1);
    chk("a_rerun_e2_ee", int'(ifa.CK_EE_o), 1);
    chk("a_rerun_e2_frame", int'(ifa.FRAME_o), 1);
    step(1);
    chk("a_rerun_e3_h", int'(ifa.HCTRs_o), 1);
    chk("a_rerun_e3_frame", int'(ifa.FRAME_o), 0);

    // ---- dut_a: asynchronous reset mid-line
    step(398);
    chk("a_mid_h", int'(ifa.HCTRs_o), 200);
    #2 rst_a_n = 1'b0;
    #1;
    chk("a_arst_h", int'(ifa.HCTRs_o), 0);
    chk("a_arst_misc", int'({ifa.CK_EE_o, ifa.ACTIVE_o, ifa.HSYNC_o, ifa.VSYNC_o, ifa.CSYNC_o,
                             ifa.BURST_o, ifa.FRAME_o, ifa.FRAME_CTRs_o}), 0);
    step(1);

    // ---- dut_b: divide 1, full frame of flags
    rst_b_n = 1'b1;
    step(1);
    chk("b_e1_ee", int'(ifb.CK_EE_o), 1);
    chk("b_e1_frame", int'(ifb.FRAME_o), 1);
    chk("b_e1_h", int'(ifb.HCTRs_o), 0);
    chk("b_e1_active", int'(ifb.ACTIVE_o), 1);
    step(1);
    for (int p = 1; p < 128; p++) begin
      int hx;
      int vx;
      logic vs_e;
      logic hs_e;
      hx   = p % 16;
      vx   = p / 16;
      vs_e = (vx >= 5 && vx <= 6);
      hs_e = (hx >= 9 && hx <= 10);
      chk("b_h", int'(ifb.HCTRs_o), hx);
      chk("b_v", int'(ifb.VCTRs_o), vx);
      chk("b_ee", int'(ifb.CK_EE_o), 1);
      chk("b_frame", int'(ifb.FRAME_o), 0);
      chk("b_hsync", int'(ifb.HSYNC_o), int'(hs_e));
      chk("b_vsync", int'(ifb.VSYNC_o), int'(vs_e));
      chk("b_csync", int'(ifb.CSYNC_o), int'(vs_e ? !hs_e : hs_e));
      chk("b_burst", int'(ifb.BURST_o), int'(hx >= 12 && hx <= 13 && !vs_e));
      chk("b_active", int'(ifb.ACTIVE_o), int'(hx <= 7 && vx <= 3));
      chk("b_fctr", int'(ifb.FRAME_CTRs_o), 0);
      step(1);
    end
    chk("b_f1_h", int'(ifb.HCTRs_o), 0);
    chk("b_f1_v", int'(ifb.VCTRs_o), 0);
    chk("b_f1_frame", int'(ifb.FRAME_o), 1);
    chk("b_f1_fctr", int'(ifb.FRAME_CTRs_o), 1);
    step(1);
    chk("b_f1_frame_end", int'(ifb.FRAME_o), 0);
    step(127);
    chk("b_f2_frame", int'(ifb.FRAME_o), 1);
    chk("b_f2_fctr", int'(ifb.FRAME_CTRs_o), 2);

    // ---- dut_b: frame counter wrap 255 -> 0
    step(32384);
    chk("b_f255_fctr", int'(ifb.FRAME_CTRs_o), 255);
    step(127);
    chk("b_last_h", int'(ifb.HCTRs_o), 15);
    chk("b_last_v", int'(ifb.VCTRs_o), 7);
    chk("b_last_frame", int'(ifb.FRAME_o), 0);
    step(1);
    chk("b_wrap_h", int'(ifb.HCTRs_o), 0);
    chk("b_wrap_v", int'(ifb.VCTRs_o), 0);
    chk("b_wrap_frame", int'(ifb.FRAME_o), 1);
    chk("b_wrap_fctr", int'(ifb.FRAME_CTRs_o), 0);
    step(1);
    chk("b_wrap_frame_end", int'(ifb.FRAME_o), 0);
    step(127);
    chk("b_post1_fctr", int'(ifb.FRAME_CTRs_o), 1);
    step(128);
    chk("b_post2_fctr", int'(ifb.FRAME_CTRs_o), 2);

    // ---- dut_b: run gating with a non-zero frame count
    step(37);
    chk("b_gate_h", int'(ifb.HCTRs_o), 5);
    chk("b_gate_v", int'(ifb.VCTRs_o), 2);
    ifb.RUN_i = 1'b0;
    step(1);
    chk("b_gate_ee", int'(ifb.CK_EE_o), 0);
    chk("b_gate_h0", int'(ifb.HCTRs_o), 0);
    chk("b_gate_v0", int'(ifb.VCTRs_o), 0);
    chk("b_gate_active", int'(ifb.ACTIVE_o), 1);
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("b_gate_frame", int'(ifb.FRAME_o), 0);
      chk("b_gate_fctr", int'(ifb.FRAME_CTRs_o), 2);
    end
    ifb.RUN_i = 1'b1;
    step(1);
    chk("b_rerun_ee", int'(ifb.CK_EE_o), 1);
    chk("b_rerun_frame", int'(ifb.FRAME_o), 1);
    step(1);
    chk("b_rerun_h", int'(ifb.HCTRs_o), 1);
    chk("b_rerun_frame_end", int'(ifb.FRAME_o), 0);

    // ---- dut_b: asynchronous reset mid-frame
    step(20);
    chk("b_mid_h", int'(ifb.HCTRs_o), 5);
    chk("b_mid_v", int'(ifb.VCTRs_o), 1);
    #2 rst_b_n = 1'b0;
    #1;
    chk("b_arst_h", int'(ifb.HCTRs_o), 0);
    chk("b_arst_v", int'(ifb.VCTRs_o), 0);
    chk("b_arst_misc", int'({ifb.CK_EE_o, ifb.ACTIVE_o, ifb.HSYNC_o, ifb.VSYNC_o, ifb.CSYNC_o,
                             ifb.BURST_o, ifb.FRAME_o, ifb.FRAME_CTRs_o}), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
